mmio_store_unit: RTL and testbench
==================================

MMIO_STORE_UNIT -- requirements
Module: mmio_store_unit

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of TX byte entries (power of two, >=2) when MMIO_TX_FIFO_EN is defined.
REQ-002 Parameter TX_ADDR, default 32'h80000008, MMIO address of UART transmit data.
REQ-003 Parameter CNT_RST_ADDR, default 32'h80000018, MMIO address of counter reset.
REQ-004 Port list SHALL be, with the clock and reset first:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- store_en_i  input  1  EX stage is executing a store this cycle.
- store_addr_i  input  32  store effective address (ALU result).
- store_data_i  input  32  store data; only [7:0] is used.
- uart_tx_in_ready_i  input  1  UART transmitter accepts a byte.
- uart_tx_in_valid_o  output  1  byte available to the UART.
- uart_tx_in_data_o  output  8  byte presented to the UART.
- tx_ready_o  output  1  buffer not full; feeds MMIO status bit 0.
- stall_o  output  1  freeze the pipeline; the TX store cannot be accepted.
- counter_rst_o  output  1  one-cycle clear for the cycle and instruction counters.
- tx_count_o  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-005 A TX write SHALL be store_en_i=1 with store_addr_i==TX_ADDR, using the full 32-bit compare.
REQ-006 A counter-reset write SHALL be store_en_i=1 with store_addr_i==CNT_RST_ADDR; the store data is ignored.
REQ-007 Stores to any other address SHALL have no effect on state or outputs.
REQ-008 stall_o SHALL be combinational, asserted exactly when a TX write is presented and the registered full flag is 1.
REQ-009 A TX write with stall_o=0 SHALL push store_data_i[7:0] at the next rising edge; a stalled write SHALL push nothing and is retried by the held pipeline.
REQ-010 uart_tx_in_valid_o SHALL equal not-empty, and uart_tx_in_data_o SHALL equal the head entry, both from registers only.
REQ-011 A pop SHALL occur on an edge where uart_tx_in_valid_o=1 and uart_tx_in_ready_i=1.
REQ-012 Bytes SHALL leave the buffer in strict FIFO order with no loss or duplication.
REQ-013 Latency: a byte pushed into an empty buffer SHALL appear on uart_tx_in_data_o with valid=1 in the cycle after the push edge.
REQ-014 A push and a pop in the same cycle on a non-empty, non-full buffer SHALL leave the occupancy unchanged.
REQ-015 When full, stall_o SHALL be asserted even if a pop occurs in the same cycle; the write is accepted the following cycle.
REQ-016 When empty, the data output SHALL hold its last value and the valid output SHALL be 0.
REQ-017 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra bit so that full and empty are distinguishable.
REQ-018 tx_ready_o SHALL be the inverse of the registered full flag.
REQ-019 counter_rst_o SHALL be a registered pulse, high for exactly one cycle following the edge that sampled a counter-reset write; back-to-back writes SHALL give back-to-back pulses.

Reset
REQ-020 Reset SHALL act asynchronously and clear all state with no clock edge required.
REQ-021 Output values while in reset and at its release:
- uart_tx_in_valid_o=0, uart_tx_in_data_o=8'h00
- tx_ready_o=1, counter_rst_o=0, tx_count_o=0
- pointers=0
REQ-022 Reset mid-transfer SHALL discard all buffered bytes, including the head being offered; no partial pop SHALL occur.
REQ-023 stall_o under reset SHALL follow REQ-008 with full=0, and so SHALL be 0.

Configuration
REQ-024 With MMIO_TX_FIFO_EN defined, the buffer SHALL be a FIFO_DEPTH-entry FIFO as specified above.
REQ-025 Without MMIO_TX_FIFO_EN, the buffer SHALL be a single holding register:
- full = valid
- FIFO_DEPTH ignored; tx_count_o is 0 or 1
- push into an empty register only; simultaneous pop and push when full still stalls per REQ-015
- all other requirements unchanged

Verification
REQ-026 Reset, then one store of 32'h41 to 0x80000008 with ready=0 -> next cycle valid=1, data=8'h41, count=1; after ready=1 for one edge -> valid=0, count=0.
REQ-027 ready=0 and 5 consecutive TX stores of 1..5 (FIFO_DEPTH=4) -> stall_o=1 only on the 5th store; after one pop, byte 5 is accepted; drained order is 1,2,3,4,5.
REQ-028 Full buffer with pop and push presented in the same cycle -> stall_o=1 that cycle; the push is accepted next cycle; count sequence 4,3,4.
REQ-029 Store to 0x80000018 -> counter_rst_o=1 for exactly one cycle, one cycle later; stores to 0x80000004 and 0x00001000 -> no output change.
REQ-030 3 bytes buffered, then rst asserted between clock edges -> valid=0, count=0 and tx_ready_o=1 immediately; no byte emitted after release.
REQ-031 Repeat REQ-026 through REQ-028 without MMIO_TX_FIFO_EN -> stall on the 2nd pending store; bytes are still delivered in order.

Source files
------------

// File: rtl/mmio_store_unit.sv
// MMIO store decoder: buffers bytes written to the UART TX address and pulses a counter reset.
// Define MMIO_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register is built.
module mmio_store_unit #(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] TX_ADDR      = 32'h8000_0008,
    parameter logic [31:0] CNT_RST_ADDR = 32'h8000_0018
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        store_en_i,
    input  logic [31:0]                 store_addr_i,
    input  logic [31:0]                 store_data_i,
    input  logic                        uart_tx_in_ready_i,
    output logic                        uart_tx_in_valid_o,
    output logic [7:0]                  uart_tx_in_data_o,
    output logic                        tx_ready_o,
    output logic                        stall_o,
    output logic                        counter_rst_o,
    output logic [$clog2(FIFO_DEPTH):0] tx_count_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic       tx_wr;
    logic       cnt_wr;
    logic       full;
    logic       push;
    logic       pop;
    logic [7:0] tx_byte;
    logic       cnt_rst_q;
    logic       cnt_rst_d;
    logic       unused_data;

    assign tx_wr       = store_en_i && (store_addr_i == TX_ADDR);
    assign cnt_wr      = store_en_i && (store_addr_i == CNT_RST_ADDR);
    assign tx_byte     = store_data_i[7:0];
    assign unused_data = ^store_data_i[31:8];

    // A full buffer stalls even when a pop happens this cycle; the write lands next cycle.
    assign stall_o    = tx_wr && full;
    assign push       = tx_wr && !full;
    assign pop        = uart_tx_in_valid_o && uart_tx_in_ready_i;
    assign tx_ready_o = !full;

    always_comb begin
        cnt_rst_d = cnt_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_rst_q <= 1'b0;
        end else begin
            cnt_rst_q <= cnt_rst_d;
        end
    end

    assign counter_rst_o = cnt_rst_q;

`ifdef MMIO_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          full_d;
    logic          valid_q;
    logic          valid_d;
    logic [7:0]    head_q;
    logic [7:0]    head_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        rd_nxt   = rd_ptr_q + 1'b1;

        if (push) begin
            mem_d[wr_ptr_q] = tx_byte;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_nxt;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The head lives in its own register so the output holds the last byte once drained.
        if (pop) begin
            if (count_q > CW'(1)) begin
                head_d = mem_q[rd_nxt];
            end else if (push) begin
                head_d = tx_byte;
            end
        end else if (push && !valid_q) begin
            head_d = tx_byte;
        end

        full_d  = (count_d == CW'(FIFO_DEPTH));
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            head_q   <= 8'h00;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    assign full               = full_q;
    assign uart_tx_in_valid_o = valid_q;
    assign uart_tx_in_data_o  = head_q;
    assign tx_count_o         = count_q;
`else
    logic       valid_q;
    logic       valid_d;
    logic [7:0] head_q;
    logic [7:0] head_d;

    // push only happens when empty and pop only when occupied, so they never coincide.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        if (push) begin
            valid_d = 1'b1;
            head_d  = tx_byte;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            head_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end

    assign full               = valid_q;
    assign uart_tx_in_valid_o = valid_q;
    assign uart_tx_in_data_o  = head_q;
    assign tx_count_o         = {{(CW-1){1'b0}}, valid_q};
`endif

endmodule

// File: tb/tb_mmio_store_unit.sv
// Directed bench for mmio_store_unit with a byte-queue scoreboard; follows MMIO_TX_FIFO_EN for depth.
module tb_mmio_store_unit;

    localparam logic [31:0] TX_ADDR  = 32'h8000_0008;
    localparam logic [31:0] CNT_ADDR = 32'h8000_0018;
`ifdef MMIO_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int NBUF = (DEPTH < 3) ? DEPTH : 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        store_en_i;
    logic [31:0] store_addr_i;
    logic [31:0] store_data_i;
    logic        uart_tx_in_ready_i;
    logic        uart_tx_in_valid_o;
    logic [7:0]  uart_tx_in_data_o;
    logic        tx_ready_o;
    logic        stall_o;
    logic        counter_rst_o;
    logic [2:0]  tx_count_o;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sb[$];
    logic [7:0]  last_byte;
    logic        crst_pend;
    logic        last_stall;

    mmio_store_unit #(
        .FIFO_DEPTH  (4),
        .TX_ADDR     (TX_ADDR),
        .CNT_RST_ADDR(CNT_ADDR)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .store_en_i        (store_en_i),
        .store_addr_i      (store_addr_i),
        .store_data_i      (store_data_i),
        .uart_tx_in_ready_i(uart_tx_in_ready_i),
        .uart_tx_in_valid_o(uart_tx_in_valid_o),
        .uart_tx_in_data_o (uart_tx_in_data_o),
        .tx_ready_o        (tx_ready_o),
        .stall_o           (stall_o),
        .counter_rst_o     (counter_rst_o),
        .tx_count_o        (tx_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] addr, input logic [31:0] data,
                         input logic rdy);
        store_en_i         = en;
        store_addr_i       = addr;
        store_data_i       = data;
        uart_tx_in_ready_i = rdy;
    endtask

    // Checks outputs mid-cycle against the model, advances the model across the edge.
    task automatic tick();
        logic       tx_w;
        logic       cnt_w;
        logic       exp_stall;
        logic [7:0] exp_data;
        @(negedge clk);
        tx_w      = store_en_i && (store_addr_i == TX_ADDR);
        cnt_w     = store_en_i && (store_addr_i == CNT_ADDR);
        exp_stall = tx_w && (sb.size() == DEPTH);
        exp_data  = (sb.size() != 0) ? sb[0] : last_byte;
        chk("stall", stall_o, exp_stall);
        chk("valid", uart_tx_in_valid_o, sb.size() != 0);
        chk("data", uart_tx_in_data_o, exp_data);
        chk("count", tx_count_o, sb.size());
        chk("tx_ready", tx_ready_o, sb.size() != DEPTH);
        chk("counter_rst", counter_rst_o, crst_pend);
        if (sb.size() != 0 && uart_tx_in_ready_i) last_byte = sb.pop_front();
        if (tx_w && !exp_stall) sb.push_back(store_data_i[7:0]);
        crst_pend  = cnt_w;
        last_stall = exp_stall;
        @(posedge clk);
        #1;
    endtask

    task automatic store_retry(input logic [7:0] b, input logic rdy);
        int n = 0;
        drive(1'b1, TX_ADDR, {24'h0, b}, rdy);
        do begin
            tick();
            n++;
        end while (last_stall && n < 8);
        chk("retry_bound", last_stall, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_bound", sb.size(), 0);
        tick();
    endtask

    initial begin
        logic [2:0] cnt_seq [3];
        sb.delete();
        last_byte  = 8'h00;
        crst_pend  = 1'b0;
        last_stall = 1'b0;

        // Reset with a TX write presented: no stall, everything cleared
        rst = 1'b1;
        drive(1'b1, TX_ADDR, 32'h5A, 1'b1);
        #2;
        chk("rst_valid", uart_tx_in_valid_o, 1'b0);
        chk("rst_data", uart_tx_in_data_o, 8'h00);
        chk("rst_tx_ready", tx_ready_o, 1'b1);
        chk("rst_counter_rst", counter_rst_o, 1'b0);
        chk("rst_count", tx_count_o, 3'd0);
        chk("rst_stall", stall_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", uart_tx_in_valid_o, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        tick();
        tick();

        // Single byte: visible one cycle after push, gone after one ready edge
        drive(1'b1, TX_ADDR, 32'h0000_0041, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("one_valid", uart_tx_in_valid_o, 1'b1);
        chk("one_data", uart_tx_in_data_o, 8'h41);
        chk("one_count", tx_count_o, 3'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("one_popped_valid", uart_tx_in_valid_o, 1'b0);
        chk("one_popped_count", tx_count_o, 3'd0);
        chk("one_hold_data", uart_tx_in_data_o, 8'h41);

        // Fill, stall on the extra store, pop+stalled push, then accept
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, TX_ADDR, i, 1'b0);
            tick();
        end
        chk("full_tx_ready", tx_ready_o, 1'b0);
        drive(1'b1, TX_ADDR, DEPTH + 1, 1'b0);
        #1;
        chk("full_stall", stall_o, 1'b1);
        tick();
        cnt_seq[0] = tx_count_o;
        drive(1'b1, TX_ADDR, DEPTH + 1, 1'b1);
        #1;
        chk("full_pop_stall", stall_o, 1'b1);
        tick();
        cnt_seq[1] = tx_count_o;
        drive(1'b1, TX_ADDR, DEPTH + 1, 1'b0);
        #1;
        chk("after_pop_stall", stall_o, 1'b0);
        tick();
        cnt_seq[2] = tx_count_o;
        chk("seq_full", cnt_seq[0], DEPTH);
        chk("seq_popped", cnt_seq[1], DEPTH - 1);
        chk("seq_refull", cnt_seq[2], DEPTH);
        drain();
        chk("drain_last", uart_tx_in_data_o, DEPTH + 1);

        // Push against a pop on an occupied buffer
        store_retry(8'hA0, 1'b0);
        store_retry(8'hA1, 1'b1);
        chk("pushpop_count", tx_count_o, 3'd1);
        chk("pushpop_head", uart_tx_in_data_o, 8'hA1);
        drain();

        // Counter reset pulse, back-to-back, and ignored addresses
        drive(1'b1, CNT_ADDR, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("crst_pulse", counter_rst_o, 1'b1);
        tick();
        chk("crst_single", counter_rst_o, 1'b0);
        drive(1'b1, CNT_ADDR, 32'h0, 1'b0);
        tick();
        chk("crst_b2b_a", counter_rst_o, 1'b1);
        tick();
        chk("crst_b2b_b", counter_rst_o, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("crst_b2b_end", counter_rst_o, 1'b0);
        drive(1'b1, 32'h8000_0004, 32'h77, 1'b0);
        tick();
        drive(1'b1, 32'h0000_1000, 32'h78, 1'b0);
        tick();
        drive(1'b0, TX_ADDR, 32'h79, 1'b0);
        tick();
        chk("other_valid", uart_tx_in_valid_o, 1'b0);
        chk("other_count", tx_count_o, 3'd0);
        chk("other_crst", counter_rst_o, 1'b0);
        chk("other_data", uart_tx_in_data_o, 8'hA1);

        // Asynchronous reset with bytes buffered
        for (int i = 0; i < NBUF; i++) begin
            drive(1'b1, TX_ADDR, 32'hC0 + i, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("pre_rst_count", tx_count_o, NBUF);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", uart_tx_in_valid_o, 1'b0);
        chk("arst_count", tx_count_o, 3'd0);
        chk("arst_tx_ready", tx_ready_o, 1'b1);
        chk("arst_data", uart_tx_in_data_o, 8'h00);
        sb.delete();
        last_byte = 8'h00;
        crst_pend = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
